// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: sequences CS-framed SPI transfers (command byte + data bytes)
// into reads and writes of an 8-bit register bank, with address auto-increment.
// Build option: define SPI_CMD_CNT_EN to add a read-only 16-bit transfer
// counter at addresses 7'h7E (LSB) and 7'h7F (MSB).
module spi_cmd_ctrl #(
  parameter int         NREG    = 8,
  parameter logic [7:0] RST_VAL = 8'h00,
  parameter logic [7:0] STATUS  = 8'hA5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_cs_n,
  input  logic                    i_rx_done,
  input  logic [7:0]              i_rx_data,
  output logic [7:0]              o_tx_data,
  output logic [NREG*8-1:0]       o_regs,
  output logic                    o_wr_stb,
  output logic [$clog2(NREG)-1:0] o_wr_addr,
  output logic                    o_err,
  output logic                    o_busy
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [2:0] {IDLE, CMD, WR, RD, ERR} state_t;

  state_t        state;
  state_t        state_nxt;

  logic          cs_meta;
  logic          cs_sync;
  logic          cs_prev;
  logic          cs_fall;

  logic [7:0]    regs [NREG];
  logic [AW-1:0] ptr;

  logic          cmd_rd;
  logic [6:0]    cmd_addr;
  logic [AW-1:0] cmd_idx;
  logic          in_range;
  logic          cmd_ok;

  logic          cnt_sel;
  logic [7:0]    cnt_first;
  logic [7:0]    cnt_next;
  logic [7:0]    rd_byte;

  // Command byte fields; only meaningful while i_rx_done is high in CMD.
  assign cmd_rd   = i_rx_data[7];
  assign cmd_addr = i_rx_data[6:0];
  assign cmd_idx  = i_rx_data[AW-1:0];
  assign in_range = (cmd_addr < 7'(NREG));
  assign cs_fall  = cs_prev & ~cs_sync;
  assign o_busy   = ~cs_sync;

  // Two-stage synchroniser for the raw chip select, plus one delayed copy for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
      cs_prev <= 1'b1;
    end else begin
      cs_meta <= i_cs_n;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
    end
  end

`ifdef SPI_CMD_CNT_EN
  logic        cnt_hit;
  logic [1:0]  cnt_idx;
  logic [15:0] xfer_cnt;
  logic        data_seen;
  logic        data_byte;

  // Byte select into the counter: 0 = LSB, 1 = MSB, anything past the MSB reads as FF.
  function automatic logic [7:0] cnt_byte(input logic [15:0] cnt, input logic [1:0] idx);
    case (idx)
      2'd0:    return cnt[7:0];
      2'd1:    return cnt[15:8];
      default: return 8'hFF;
    endcase
  endfunction

  assign cnt_hit   = (cmd_addr[6:1] == 6'h3F);
  assign cmd_ok    = in_range | cnt_hit;
  assign data_byte = i_rx_done & ((state == WR) | (state == RD));
  assign cnt_first = cnt_byte(xfer_cnt, {1'b0, cmd_addr[0]});
  assign cnt_next  = cnt_byte(xfer_cnt, cnt_idx);

  // Counter window tracking and end-of-transfer counting; a transfer counts once CS rises.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_sel   <= 1'b0;
      cnt_idx   <= 2'd0;
      data_seen <= 1'b0;
      xfer_cnt  <= 16'd0;
    end else begin
      if (state == IDLE) begin
        cnt_sel   <= 1'b0;
        data_seen <= 1'b0;
      end
      if (state == CMD && i_rx_done && !in_range && cnt_hit) begin
        cnt_sel <= 1'b1;
        cnt_idx <= cmd_addr[0] ? 2'd2 : 2'd1;
      end
      if (state == RD && i_rx_done && cnt_sel && cnt_idx != 2'd2)
        cnt_idx <= cnt_idx + 2'd1;
      if (data_byte)
        data_seen <= 1'b1;
      if (state != IDLE && cs_sync && (data_seen || data_byte)) begin
        xfer_cnt  <= xfer_cnt + 16'd1;
        data_seen <= 1'b0;
      end
    end
  end
`else
  assign cmd_ok    = in_range;
  assign cnt_sel   = 1'b0;
  assign cnt_first = 8'hFF;
  assign cnt_next  = 8'hFF;
`endif

  // Byte loaded into the next read slot: counter window or register at ptr.
  assign rd_byte = cnt_sel ? cnt_next : regs[ptr];

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state; CS high overrides everything, after any same-cycle byte is processed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = CMD;
      CMD:     if (i_rx_done) begin
                 if (cmd_ok) state_nxt = cmd_rd ? RD : WR;
                 else        state_nxt = ERR;
               end
      default: state_nxt = state;
    endcase
    if (cs_sync && state != IDLE) state_nxt = IDLE;
  end

  // Datapath: MISO byte, register bank, pointer, write strobe and error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx_data <= STATUS;
      o_wr_stb  <= 1'b0;
      o_wr_addr <= '0;
      o_err     <= 1'b0;
      ptr       <= '0;
      for (int k = 0; k < NREG; k++) regs[k] <= RST_VAL;
    end else begin
      o_wr_stb <= 1'b0;
      o_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) o_tx_data <= STATUS;
        end
        CMD: begin
          if (i_rx_done) begin
            if (in_range) begin
              if (cmd_rd) begin
                o_tx_data <= regs[cmd_idx];
                ptr       <= cmd_idx + AW'(1);
              end else begin
                o_tx_data <= i_rx_data;
                ptr       <= cmd_idx;
              end
            end else if (cmd_ok) begin
              o_tx_data <= cmd_rd ? cnt_first : i_rx_data;
            end else begin
              o_err     <= 1'b1;
              o_tx_data <= 8'hFF;
            end
          end
        end
        WR: begin
          if (i_rx_done) begin
            o_tx_data <= i_rx_data;
            if (!cnt_sel) begin
              regs[ptr] <= i_rx_data;
              o_wr_stb  <= 1'b1;
              o_wr_addr <= ptr;
              ptr       <= ptr + AW'(1);
            end
          end
        end
        RD: begin
          if (i_rx_done) begin
            o_tx_data <= rd_byte;
            if (!cnt_sel) ptr <= ptr + AW'(1);
          end
        end
        default: o_tx_data <= 8'hFF;
      endcase
    end
  end

  // Flatten the register bank: reg k occupies o_regs[8k+7:8k].
  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign o_regs[8*k +: 8] = regs[k];
  end

endmodule
